// File: rtl/game_fsm_multi_pkg.sv
// Shared game types for the multi-player game FSM.
// Terrain encoding, map geometry and player limits.
package game_fsm_multi_pkg;

  localparam int GAME_MAP_WIDTH  = 8;
  localparam int GAME_MAP_HEIGHT = 8;
  localparam int MAP_IDX_SIZE_X  = $clog2(GAME_MAP_WIDTH);
  localparam int MAP_IDX_SIZE_Y  = $clog2(GAME_MAP_HEIGHT);
  localparam int MAX_PLAYERS     = 4;
  localparam int LIVES_W         = 4;
  localparam int PID_W           = $clog2(MAX_PLAYERS);

  typedef logic [PID_W-1:0] player_id_t;

  typedef enum logic [1:0] {
    PRE_GAME,
    GAME_RUNNING,
    GAME_WON,
    GAME_LOST
  } game_state_t;

  typedef enum logic [1:0] {
    TERRAIN_GRASS,
    TERRAIN_PATH,
    TERRAIN_WATER,
    TERRAIN_LAVA
  } terrain_t;

  // Water and lava kill; everything else is walkable.
  function automatic logic terrain_ok(terrain_t t);
    return (t == TERRAIN_GRASS) || (t == TERRAIN_PATH);
  endfunction

endpackage

// File: rtl/game_fsm_multi_if.sv
// Terrain map write bus, broadcast to every player's checker.
// Master drives writes; slave receives them.
interface game_fsm_multi_if
  import game_fsm_multi_pkg::*;
();
  logic                      write_enable;
  logic [MAP_IDX_SIZE_X-1:0] write_x;
  logic [MAP_IDX_SIZE_Y-1:0] write_y;
  terrain_t                  write_data;

  modport master (
    output write_enable, write_x,
    output write_y, write_data
  );

  modport slave (
    input write_enable, write_x,
    input write_y, write_data
  );
endinterface

// File: rtl/game_player.sv
// One avatar: position, lives, alive flag and move-rate limiter.
// Reports win/hazard hits for the round FSM.
module game_player
  import game_fsm_multi_pkg::*;
#(
  parameter int START_POS_X   = 0,
  parameter int START_POS_Y   = 0,
  parameter int WIN_POS_X     = GAME_MAP_WIDTH - 1,
  parameter int WIN_POS_Y     = GAME_MAP_HEIGHT - 1,
  parameter int NUM_LIVES     = 3,
  parameter int MOVE_COOLDOWN = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      hold,
  input  logic                      run,
  input  logic                      up,
  input  logic                      down,
  input  logic                      left,
  input  logic                      right,
  game_fsm_multi_if.slave           wr,
  output logic [MAP_IDX_SIZE_X-1:0] pos_x,
  output logic [MAP_IDX_SIZE_Y-1:0] pos_y,
  output logic [LIVES_W-1:0]        lives,
  output logic                      alive,
  output logic                      hit_win,
  output logic                      hit_hazard
);

  localparam int CW = $clog2(MOVE_COOLDOWN + 1);
  localparam logic [MAP_IDX_SIZE_X-1:0] X_MAX = MAP_IDX_SIZE_X'(GAME_MAP_WIDTH - 1);
  localparam logic [MAP_IDX_SIZE_Y-1:0] Y_MAX = MAP_IDX_SIZE_Y'(GAME_MAP_HEIGHT - 1);
  localparam logic [MAP_IDX_SIZE_X-1:0] SX = MAP_IDX_SIZE_X'(START_POS_X);
  localparam logic [MAP_IDX_SIZE_Y-1:0] SY = MAP_IDX_SIZE_Y'(START_POS_Y);

  logic [CW-1:0]             cool;
  logic [MAP_IDX_SIZE_X-1:0] cand_x;
  logic [MAP_IDX_SIZE_Y-1:0] cand_y;
  logic                      move;
  logic                      ok;

  // Highest-priority pressed button picks the move; a clamped one is dropped.
  always_comb begin
    cand_x = pos_x;
    cand_y = pos_y;
    move   = 1'b0;
    if (run && alive && cool == '0) begin
      if (up) begin
        if (pos_y != Y_MAX) begin
          cand_y = pos_y + 1'b1;
          move   = 1'b1;
        end
      end else if (down) begin
        if (pos_y != '0) begin
          cand_y = pos_y - 1'b1;
          move   = 1'b1;
        end
      end else if (left) begin
        if (pos_x != '0) begin
          cand_x = pos_x - 1'b1;
          move   = 1'b1;
        end
      end else if (right) begin
        if (pos_x != X_MAX) begin
          cand_x = pos_x + 1'b1;
          move   = 1'b1;
        end
      end
    end
  end

  position_checker u_chk (
    .clk     (clk),
    .reset_n (reset_n),
    .wr      (wr),
    .x       (cand_x),
    .y       (cand_y),
    .ok      (ok)
  );

  assign hit_hazard = move && !ok;
  assign hit_win    = move && ok
                   && cand_x == MAP_IDX_SIZE_X'(WIN_POS_X)
                   && cand_y == MAP_IDX_SIZE_Y'(WIN_POS_Y);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pos_x <= SX;
      pos_y <= SY;
      lives <= LIVES_W'(NUM_LIVES);
      alive <= 1'b1;
      cool  <= '0;
    end else if (hold) begin
      pos_x <= SX;
      pos_y <= SY;
      lives <= LIVES_W'(NUM_LIVES);
      alive <= 1'b1;
      cool  <= '0;
    end else if (run) begin
      if (cool != '0)
        cool <= cool - 1'b1;
      if (hit_hazard) begin
        pos_x <= SX;
        pos_y <= SY;
        lives <= lives - 1'b1;
        cool  <= CW'(MOVE_COOLDOWN);
        if (lives == LIVES_W'(1))
          alive <= 1'b0;
      end else if (move) begin
        pos_x <= cand_x;
        pos_y <= cand_y;
        cool  <= CW'(MOVE_COOLDOWN);
      end
    end
  end

endmodule

// File: rtl/position_checker.sv
// Private copy of the terrain map; answers whether a cell is safe.
// Writes land at the clock edge and affect checks from the next cycle.
module position_checker
  import game_fsm_multi_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset_n,
  game_fsm_multi_if.slave           wr,
  input  logic [MAP_IDX_SIZE_X-1:0] x,
  input  logic [MAP_IDX_SIZE_Y-1:0] y,
  output logic                      ok
);

  terrain_t map_q [GAME_MAP_HEIGHT][GAME_MAP_WIDTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < GAME_MAP_HEIGHT; r++)
        for (int c = 0; c < GAME_MAP_WIDTH; c++)
          map_q[r][c] <= TERRAIN_GRASS;
    end else if (wr.write_enable) begin
      map_q[wr.write_y][wr.write_x] <= wr.write_data;
    end
  end

  assign ok = terrain_ok(map_q[y][x]);

endmodule

// File: rtl/game_fsm_multi.sv
// Multi-player round FSM: start, win, loss and screen selects.
// GAME_FSM_ROUND_TIMEOUT_EN adds a round time limit.
module game_fsm_multi
  import game_fsm_multi_pkg::*;
#(
  parameter int NUM_PLAYERS   = 2,
  parameter int START_POS_X   = 0,
  parameter int START_POS_Y   = 0,
  parameter int WIN_POS_X     = GAME_MAP_WIDTH - 1,
  parameter int WIN_POS_Y     = GAME_MAP_HEIGHT - 1,
  parameter int NUM_LIVES     = 3,
  parameter int MOVE_COOLDOWN = 4,
  parameter int ROUND_CYCLES  = 1000000
) (
  input  logic                                       clk,
  input  logic                                       reset_n,
  input  logic [NUM_PLAYERS-1:0]                     btn_up,
  input  logic [NUM_PLAYERS-1:0]                     btn_down,
  input  logic [NUM_PLAYERS-1:0]                     btn_left,
  input  logic [NUM_PLAYERS-1:0]                     btn_right,
  input  logic [NUM_PLAYERS-1:0]                     btn_A,
  input  logic [NUM_PLAYERS-1:0]                     btn_B,
  input  logic [NUM_PLAYERS-1:0]                     btn_start,
  game_fsm_multi_if.slave                            wr,
  output logic [NUM_PLAYERS-1:0][MAP_IDX_SIZE_X-1:0] player_pos_x,
  output logic [NUM_PLAYERS-1:0][MAP_IDX_SIZE_Y-1:0] player_pos_y,
  output logic [NUM_PLAYERS-1:0][LIVES_W-1:0]        player_lives,
  output logic [NUM_PLAYERS-1:0]                     player_alive,
  output player_id_t                                 winner_id,
  output logic                                       show_pre_game_screen,
  output logic                                       show_won_game_screen,
  output logic                                       show_lost_game_screen
);

  game_state_t            state, state_d;
  player_id_t             winner_d;
  logic [NUM_PLAYERS-1:0] start_q, start_edge;
  logic [NUM_PLAYERS-1:0] hit_win, hit_hazard, dying;
  logic                   run, hold, all_dead, timeout;
  logic                   unused_btn;

  assign unused_btn = ^{btn_A, btn_B};
  assign start_edge = btn_start & ~start_q;
  assign run        = state == GAME_RUNNING;
  assign hold       = state_d == PRE_GAME;

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_player
    game_player #(
      .START_POS_X   (START_POS_X),
      .START_POS_Y   (START_POS_Y),
      .WIN_POS_X     (WIN_POS_X),
      .WIN_POS_Y     (WIN_POS_Y),
      .NUM_LIVES     (NUM_LIVES),
      .MOVE_COOLDOWN (MOVE_COOLDOWN)
    ) u_player (
      .clk        (clk),
      .reset_n    (reset_n),
      .hold       (hold),
      .run        (run),
      .up         (btn_up[g]),
      .down       (btn_down[g]),
      .left       (btn_left[g]),
      .right      (btn_right[g]),
      .wr         (wr),
      .pos_x      (player_pos_x[g]),
      .pos_y      (player_pos_y[g]),
      .lives      (player_lives[g]),
      .alive      (player_alive[g]),
      .hit_win    (hit_win[g]),
      .hit_hazard (hit_hazard[g])
    );
    assign dying[g] = hit_hazard[g]
                   && player_lives[g] == LIVES_W'(1);
  end

  assign all_dead = &(~player_alive | dying);

`ifdef GAME_FSM_ROUND_TIMEOUT_EN
  logic [31:0] round_cnt;

  assign timeout = round_cnt == 32'(ROUND_CYCLES - 1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      round_cnt <= '0;
    else if (!run)
      round_cnt <= '0;
    else
      round_cnt <= round_cnt + 1'b1;
  end
`else
  logic unused_round;

  assign timeout      = 1'b0;
  assign unused_round = ^ROUND_CYCLES;
`endif

  // Win beats both the last death and the timeout in the same cycle.
  always_comb begin
    state_d  = state;
    winner_d = winner_id;
    unique case (state)
      PRE_GAME:
        if (|start_edge) state_d = GAME_RUNNING;
      GAME_RUNNING:
        if (|hit_win) begin
          state_d = GAME_WON;
          for (int i = NUM_PLAYERS - 1; i >= 0; i--)
            if (hit_win[i]) winner_d = PID_W'(i);
        end else if (all_dead || timeout) begin
          state_d = GAME_LOST;
        end
      GAME_WON, GAME_LOST:
        if (|start_edge) state_d = PRE_GAME;
      default:
        state_d = PRE_GAME;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= PRE_GAME;
      winner_id <= '0;
      start_q   <= '0;
    end else begin
      state     <= state_d;
      winner_id <= winner_d;
      start_q   <= btn_start;
    end
  end

  assign show_pre_game_screen  = state == PRE_GAME;
  assign show_won_game_screen  = state == GAME_WON;
  assign show_lost_game_screen = state == GAME_LOST;

endmodule

// File: tb/tb_game_fsm_multi.sv
// Directed and random bench for game_fsm_multi.
// Compares every cycle against a rule-level model of the round.
module tb_game_fsm_multi;
  import game_fsm_multi_pkg::*;

  localparam int NP = 3;
  localparam int MC = 4;
  localparam int NL = 3;
  localparam int WX = 2;
  localparam int WY = 2;
  localparam int RC = 20;
  localparam int UP = 0, DN = 1, LT = 2, RT = 3;

  logic clk = 1'b0;
  logic reset_n;
  logic [NP-1:0] bu, bd, bl, br, ba, bb, bs;
  logic [NP-1:0][MAP_IDX_SIZE_X-1:0] px;
  logic [NP-1:0][MAP_IDX_SIZE_Y-1:0] py;
  logic [NP-1:0][LIVES_W-1:0] lv;
  logic [NP-1:0] alive;
  player_id_t winner_id;
  logic s_pre, s_won, s_lost;

  game_fsm_multi_if wr ();

  game_fsm_multi #(
    .NUM_PLAYERS   (NP),
    .START_POS_X   (0),
    .START_POS_Y   (0),
    .WIN_POS_X     (WX),
    .WIN_POS_Y     (WY),
    .NUM_LIVES     (NL),
    .MOVE_COOLDOWN (MC),
    .ROUND_CYCLES  (RC)
  ) dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .btn_up                (bu),
    .btn_down              (bd),
    .btn_left              (bl),
    .btn_right             (br),
    .btn_A                 (ba),
    .btn_B                 (bb),
    .btn_start             (bs),
    .wr                    (wr),
    .player_pos_x          (px),
    .player_pos_y          (py),
    .player_lives          (lv),
    .player_alive          (alive),
    .winner_id             (winner_id),
    .show_pre_game_screen  (s_pre),
    .show_won_game_screen  (s_won),
    .show_lost_game_screen (s_lost)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: 0 pre, 1 running, 2 won, 3 lost
  int mx[NP], my[NP], ml[NP], mcd[NP];
  bit ma[NP];
  int ms, mwin, mrc;
  bit [NP-1:0] mprev;
  bit haz[GAME_MAP_WIDTH][GAME_MAP_HEIGHT];

  task automatic respawn_all();
    for (int i = 0; i < NP; i++) begin
      mx[i] = 0; my[i] = 0; ml[i] = NL;
      ma[i] = 1'b1; mcd[i] = 0;
    end
  endtask

  task automatic model_reset();
    respawn_all();
    ms = 0; mwin = 0; mrc = 0; mprev = '0;
    for (int x = 0; x < GAME_MAP_WIDTH; x++)
      for (int y = 0; y < GAME_MAP_HEIGHT; y++)
        haz[x][y] = 1'b0;
  endtask

  task automatic model_step();
    bit [NP-1:0] sedge;
    int nx, ny, dx, dy, first_win;
    bit all_dead;
    sedge = bs & ~mprev;
    mprev = bs;
    first_win = -1;
    case (ms)
      0: begin
        respawn_all();
        mrc = 0;
        if (|sedge) ms = 1;
      end
      1: begin
        for (int i = 0; i < NP; i++) begin
          if (mcd[i] > 0) mcd[i]--;
          else if (ma[i]) begin
            dx = 0; dy = 0;
            if (bu[i]) dy = 1;
            else if (bd[i]) dy = -1;
            else if (bl[i]) dx = -1;
            else if (br[i]) dx = 1;
            nx = mx[i] + dx;
            ny = my[i] + dy;
            if ((dx != 0 || dy != 0) && nx >= 0 && nx < GAME_MAP_WIDTH
                && ny >= 0 && ny < GAME_MAP_HEIGHT) begin
              mcd[i] = MC;
              if (haz[nx][ny]) begin
                mx[i] = 0; my[i] = 0; ml[i]--;
                if (ml[i] == 0) ma[i] = 1'b0;
              end else begin
                mx[i] = nx; my[i] = ny;
                if (nx == WX && ny == WY && first_win < 0) first_win = i;
              end
            end
          end
        end
        all_dead = 1'b1;
        for (int i = 0; i < NP; i++) if (ma[i]) all_dead = 1'b0;
        if (first_win >= 0) begin
          ms = 2; mwin = first_win;
        end else if (all_dead) ms = 3;
`ifdef GAME_FSM_ROUND_TIMEOUT_EN
        else if (mrc == RC - 1) ms = 3;
`endif
        mrc++;
      end
      default:
        if (|sedge) begin
          ms = 0;
          respawn_all();
        end
    endcase
    if (wr.write_enable)
      haz[wr.write_x][wr.write_y] =
        (wr.write_data == TERRAIN_WATER) || (wr.write_data == TERRAIN_LAVA);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < NP; i++) begin
      chk($sformatf("pos_x%0d", i), 32'(px[i]), mx[i]);
      chk($sformatf("pos_y%0d", i), 32'(py[i]), my[i]);
      chk($sformatf("lives%0d", i), 32'(lv[i]), ml[i]);
      chk($sformatf("alive%0d", i), 32'(alive[i]), 32'(ma[i]));
    end
    chk("screens", {29'd0, s_pre, s_won, s_lost},
        {29'd0, ms == 0, ms == 2, ms == 3});
    if (ms == 2) chk("winner_id", 32'(winner_id), mwin);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic clear_in();
    bu = '0; bd = '0; bl = '0; br = '0; bs = '0;
    wr.write_enable = 1'b0;
  endtask

  task automatic idle(input int n);
    clear_in();
    repeat (n) step();
  endtask

  task automatic press(input bit [NP-1:0] m, input int dir);
    clear_in();
    case (dir)
      UP: bu = m;
      DN: bd = m;
      LT: bl = m;
      default: br = m;
    endcase
    step();
    idle(MC);
  endtask

  task automatic pulse_start(input bit [NP-1:0] m);
    clear_in();
    bs = m;
    step();
    bs = '0;
    step();
  endtask

  task automatic write_map(input int x, input int y, input terrain_t d);
    clear_in();
    wr.write_enable = 1'b1;
    wr.write_x = MAP_IDX_SIZE_X'(x);
    wr.write_y = MAP_IDX_SIZE_Y'(y);
    wr.write_data = d;
    step();
    wr.write_enable = 1'b0;
  endtask

  task automatic async_reset();
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("async_reset_pre", 32'(s_pre), 1);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    int r;
    reset_n = 1'b0;
    ba = '0; bb = '0;
    clear_in();
    wr.write_x = '0; wr.write_y = '0; wr.write_data = TERRAIN_GRASS;
    model_reset();
    #12;
    compare_all();
    chk("reset_winner", 32'(winner_id), 0);
    reset_n = 1'b1;

    pulse_start(3'b010);
    chk("running_after_start", {30'd0, s_pre, s_lost}, 0);

    clear_in();
    br = 3'b001;
    repeat (12) step();
    chk("x0_after_hold_right", 32'(px[0]), 3);
    chk("x1_unchanged", 32'(px[1]), 0);
    idle(MC);

    bl = 3'b001;
    repeat (18) step();
    chk("x0_clamped_left", 32'(px[0]), 0);
    bl = '0;
    br = 3'b001;
    step();
    chk("x0_right_after_block", 32'(px[0]), 1);
    idle(MC);
    press(3'b001, LT);

    write_map(1, 0, TERRAIN_LAVA);
    for (int k = 0; k < 3; k++) begin
      press(3'b111, RT);
      chk("lives0_hazard", 32'(lv[0]), NL - 1 - k);
    end
    chk("alive0_dead", 32'(alive[0]), 0);
    chk("lost_screen", 32'(s_lost), 1);

    pulse_start(3'b001);
    chk("pre_after_lost", 32'(s_pre), 1);
    chk("lives_restored", 32'(lv[0]), NL);
    write_map(1, 0, TERRAIN_GRASS);

    pulse_start(3'b001);
    press(3'b101, UP);
    press(3'b101, UP);
    press(3'b101, RT);
    press(3'b101, RT);
    chk("won_screen", 32'(s_won), 1);
    chk("winner_lowest", 32'(winner_id), 0);
    pulse_start(3'b100);
    chk("pre_after_won", 32'(s_pre), 1);
    chk("lives_after_won", 32'(lv[2]), NL);

    pulse_start(3'b001);
    press(3'b110, RT);
    press(3'b110, RT);
    press(3'b110, UP);
    press(3'b110, UP);
    chk("winner_p1", 32'(winner_id), 1);
    pulse_start(3'b010);

    pulse_start(3'b001);
    for (int n = 0; n < 1500; n++) begin
      bu = NP'($urandom) & NP'($urandom);
      bd = NP'($urandom) & NP'($urandom);
      bl = NP'($urandom) & NP'($urandom);
      br = NP'($urandom) & NP'($urandom);
      bs = ($urandom_range(0, 40) == 0) ? NP'($urandom) : '0;
      wr.write_enable = ($urandom_range(0, 7) == 0);
      wr.write_x = MAP_IDX_SIZE_X'($urandom);
      wr.write_y = MAP_IDX_SIZE_Y'($urandom);
      r = $urandom_range(0, 5);
      wr.write_data = (r == 0) ? TERRAIN_LAVA :
                      (r == 1) ? TERRAIN_WATER :
                      (r < 4)  ? TERRAIN_PATH : TERRAIN_GRASS;
      step();
    end

    async_reset();
    pulse_start(3'b001);
    press(3'b001, UP);
    async_reset();
    chk("async_y0", 32'(py[0]), 0);

`ifdef GAME_FSM_ROUND_TIMEOUT_EN
    pulse_start(3'b001);
    idle(RC - 2);
    chk("timeout_still_running", 32'(s_lost), 0);
    idle(1);
    chk("timeout_lost", 32'(s_lost), 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
